rob_mw: RTL and testbench

- Parametrised reorder buffer, successor to the single-entry-per-cycle ROB.
- Circular buffer of DEPTH entries; accepts one dispatch per cycle.
- Marks entries complete from a CDB broadcast by ROB index.
- Retires up to RET_W consecutive completed head entries per cycle, in order, and supports branch-mispredict tail squash.
- Sits between dispatch (tag allocation from the free list) and retire (arch map update, free-list return of Told).

---
 rtl/rob_mw_if.sv | 40 ++++
 rtl/rob_mw.sv | 185 ++++++++++++++++++
 tb/tb_rob_mw.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_mw_if.sv
// Reorder-buffer port bundle: dispatch, completion, squash and retire channels plus occupancy status.
interface rob_mw_if #(
  parameter int DEPTH  = 32,
  parameter int TAG_W  = 6,
  parameter int AREG_W = 5,
  parameter int RET_W  = 2,
  parameter int IDX_W  = $clog2(DEPTH)
) ();
  logic                    dispatch_valid;
  logic [TAG_W-1:0]        dispatch_T;
  logic [TAG_W-1:0]        dispatch_Told;
  logic [AREG_W-1:0]       dispatch_areg;
  logic                    dispatch_ready;
  logic [IDX_W-1:0]        dispatch_idx;
  logic                    cdb_valid;
  logic [IDX_W-1:0]        cdb_idx;
  logic                    squash_valid;
  logic [IDX_W-1:0]        squash_idx;
  logic [RET_W-1:0]        retire_valid;
  logic [RET_W*TAG_W-1:0]  retire_T;
  logic [RET_W*TAG_W-1:0]  retire_Told;
  logic [RET_W*AREG_W-1:0] retire_areg;
  logic [IDX_W:0]          count;
  logic                    empty;
  logic                    full;

  modport master (
    output dispatch_valid, dispatch_T, dispatch_Told, dispatch_areg,
           cdb_valid, cdb_idx, squash_valid, squash_idx,
    input  dispatch_ready, dispatch_idx, retire_valid, retire_T, retire_Told,
           retire_areg, count, empty, full
  );

  modport slave (
    input  dispatch_valid, dispatch_T, dispatch_Told, dispatch_areg,
           cdb_valid, cdb_idx, squash_valid, squash_idx,
    output dispatch_ready, dispatch_idx, retire_valid, retire_T, retire_Told,
           retire_areg, count, empty, full
  );
endinterface

// File: rtl/rob_mw.sv
// Multi-retire reorder buffer: one dispatch per cycle, CDB completion, up to RET_W in-order retires, tail squash.
// Optional ROB_MW_PERF_EN adds saturating full-stall and retired-instruction counters.
module rob_mw #(
  parameter int DEPTH  = 32,
  parameter int TAG_W  = 6,
  parameter int AREG_W = 5,
  parameter int RET_W  = 2,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset,
  rob_mw_if.slave     rob
`ifdef ROB_MW_PERF_EN
  ,
  output logic [31:0] perf_full_cycles,
  output logic [31:0] perf_retired
`endif
);

  logic [DEPTH-1:0]        valid_r;
  logic [DEPTH-1:0]        done_r;
  logic [TAG_W-1:0]        t_r    [DEPTH];
  logic [TAG_W-1:0]        told_r [DEPTH];
  logic [AREG_W-1:0]       areg_r [DEPTH];
  logic [IDX_W-1:0]        head_r;
  logic [IDX_W-1:0]        tail_r;
  logic [IDX_W:0]          count_r;
  logic                    empty_r;
  logic                    full_r;
  logic                    ready_r;

  logic [IDX_W-1:0]        lane_s;
  logic                    chain_s;
  logic [RET_W-1:0]        ret_valid_s;
  logic [IDX_W:0]          ret_cnt_s;
  logic [DEPTH-1:0]        ret_mask_s;
  logic [RET_W*TAG_W-1:0]  ret_t_s;
  logic [RET_W*TAG_W-1:0]  ret_told_s;
  logic [RET_W*AREG_W-1:0] ret_areg_s;

  logic                    squash_hit_s;
  logic [IDX_W-1:0]        sq_age_s;
  logic [IDX_W-1:0]        age_s;
  logic [DEPTH-1:0]        kill_mask_s;
  logic                    disp_acc_s;
  logic                    cdb_hit_s;

  logic [IDX_W-1:0]        head_n_s;
  logic [IDX_W-1:0]        tail_n_s;
  logic [IDX_W:0]          count_n_s;

  // Retire group: the contiguous run of valid+done entries starting at head.
  always_comb begin
    lane_s      = head_r;
    chain_s     = 1'b1;
    ret_valid_s = '0;
    ret_cnt_s   = '0;
    ret_mask_s  = '0;
    ret_t_s     = '0;
    ret_told_s  = '0;
    ret_areg_s  = '0;
    for (int k = 0; k < RET_W; k++) begin
      lane_s                          = head_r + IDX_W'(k);
      chain_s                         = chain_s & valid_r[lane_s] & done_r[lane_s];
      ret_valid_s[k]                  = chain_s;
      ret_mask_s[lane_s]              = chain_s;
      ret_cnt_s                       = ret_cnt_s + {{IDX_W{1'b0}}, chain_s};
      ret_t_s[k*TAG_W +: TAG_W]       = t_r[lane_s];
      ret_told_s[k*TAG_W +: TAG_W]    = told_r[lane_s];
      ret_areg_s[k*AREG_W +: AREG_W]  = areg_r[lane_s];
    end
  end

  // Squash kill set: live entries whose age from head exceeds the branch's age.
  always_comb begin
    squash_hit_s = rob.squash_valid & valid_r[rob.squash_idx];
    sq_age_s     = rob.squash_idx - head_r;
    age_s        = '0;
    kill_mask_s  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age_s          = IDX_W'(i) - head_r;
      kill_mask_s[i] = squash_hit_s & valid_r[i] & (age_s > sq_age_s);
    end
  end

  assign disp_acc_s = rob.dispatch_valid & ready_r & ~squash_hit_s;
  assign cdb_hit_s  = rob.cdb_valid & valid_r[rob.cdb_idx] & ~kill_mask_s[rob.cdb_idx];

  // Pointer and occupancy next-state; a squash rebuilds count from the branch age.
  always_comb begin
    head_n_s = head_r + ret_cnt_s[IDX_W-1:0];
    if (squash_hit_s) begin
      tail_n_s  = rob.squash_idx + {{(IDX_W-1){1'b0}}, 1'b1};
      count_n_s = {1'b0, sq_age_s} + {{IDX_W{1'b0}}, 1'b1} - ret_cnt_s;
    end else begin
      tail_n_s  = tail_r + {{(IDX_W-1){1'b0}}, disp_acc_s};
      count_n_s = count_r + {{IDX_W{1'b0}}, disp_acc_s} - ret_cnt_s;
    end
  end

  // Pointer, count and registered status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      head_r  <= head_n_s;
      tail_r  <= tail_n_s;
      count_r <= count_n_s;
      empty_r <= (count_n_s == '0);
      full_r  <= (count_n_s == (IDX_W+1)'(DEPTH));
      ready_r <= (count_n_s != (IDX_W+1)'(DEPTH));
    end
  end

  // Per-entry valid/done: dispatch allocates, retire/squash free, CDB completes.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_r <= '0;
      done_r  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (disp_acc_s && (tail_r == IDX_W'(i))) begin
          valid_r[i] <= 1'b1;
          done_r[i]  <= 1'b0;
        end else if (kill_mask_s[i] || ret_mask_s[i]) begin
          valid_r[i] <= 1'b0;
          done_r[i]  <= 1'b0;
        end else if (cdb_hit_s && (rob.cdb_idx == IDX_W'(i))) begin
          done_r[i]  <= 1'b1;
        end else begin
          done_r[i]  <= done_r[i];
        end
      end
    end
  end

  // Payload is only meaningful while valid, so it needs no reset.
  always_ff @(posedge clock) begin
    if (disp_acc_s) begin
      t_r[tail_r]    <= rob.dispatch_T;
      told_r[tail_r] <= rob.dispatch_Told;
      areg_r[tail_r] <= rob.dispatch_areg;
    end
  end

  assign rob.dispatch_ready = ready_r;
  assign rob.dispatch_idx   = tail_r;
  assign rob.retire_valid   = ret_valid_s;
  assign rob.retire_T       = ret_t_s;
  assign rob.retire_Told    = ret_told_s;
  assign rob.retire_areg    = ret_areg_s;
  assign rob.count          = count_r;
  assign rob.empty          = empty_r;
  assign rob.full           = full_r;

`ifdef ROB_MW_PERF_EN
  logic [31:0] perf_full_r;
  logic [31:0] perf_ret_r;
  logic [32:0] perf_sum_s;

  assign perf_sum_s = {1'b0, perf_ret_r} + 33'(ret_cnt_s);

  // Saturating performance counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_full_r <= 32'd0;
      perf_ret_r  <= 32'd0;
    end else begin
      if (full_r && rob.dispatch_valid && (perf_full_r != 32'hFFFF_FFFF)) begin
        perf_full_r <= perf_full_r + 32'd1;
      end
      perf_ret_r <= perf_sum_s[32] ? 32'hFFFF_FFFF : perf_sum_s[31:0];
    end
  end

  assign perf_full_cycles = perf_full_r;
  assign perf_retired     = perf_ret_r;
`endif

endmodule

// File: tb/tb_rob_mw.sv
// Scoreboard bench for rob_mw: a queue of in-flight entries predicts every retire lane and the occupancy each cycle.
module tb_rob_mw;
  localparam int DEPTH  = 32;
  localparam int TAG_W  = 6;
  localparam int AREG_W = 5;
  localparam int RET_W  = 2;
  localparam int IDX_W  = $clog2(DEPTH);

  typedef struct {
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  t;
    logic [TAG_W-1:0]  told;
    logic [AREG_W-1:0] areg;
    bit                done;
  } ent_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  ent_t             q[$];
  logic [IDX_W-1:0] exp_tail = '0;
  bit               mon_live;
  logic [RET_W-1:0] mon_mask;
  int               mon_n;

  rob_mw_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .AREG_W(AREG_W), .RET_W(RET_W)) rif ();

`ifdef ROB_MW_PERF_EN
  logic [31:0] perf_full_cycles;
  logic [31:0] perf_retired;
`endif

  rob_mw #(.DEPTH(DEPTH), .TAG_W(TAG_W), .AREG_W(AREG_W), .RET_W(RET_W)) dut (
    .clock (clock),
    .reset (reset),
    .rob   (rif)
`ifdef ROB_MW_PERF_EN
    ,
    .perf_full_cycles (perf_full_cycles),
    .perf_retired     (perf_retired)
`endif
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Predicted occupancy and retire lanes, compared mid-cycle; retired entries leave the scoreboard.
  always @(negedge clock) begin
    if (!reset) begin
      check_eq("count", rif.count, 64'(q.size()));
      check_eq("empty", rif.empty, 64'(q.size() == 0));
      check_eq("full", rif.full, 64'(q.size() == DEPTH));
      check_eq("ready", rif.dispatch_ready, 64'(q.size() != DEPTH));
      mon_live = 1'b1;
      mon_mask = '0;
      mon_n    = 0;
      for (int k = 0; k < RET_W; k++) begin
        if (mon_live && (k < q.size())) begin
          if (q[k].done) begin
            mon_mask[k] = 1'b1;
            mon_n++;
          end else begin
            mon_live = 1'b0;
          end
        end else begin
          mon_live = 1'b0;
        end
      end
      check_eq("retire_valid", rif.retire_valid, 64'(mon_mask));
      for (int k = 0; k < mon_n; k++) begin
        check_eq("retire_T", rif.retire_T[k*TAG_W +: TAG_W], q[k].t);
        check_eq("retire_Told", rif.retire_Told[k*TAG_W +: TAG_W], q[k].told);
        check_eq("retire_areg", rif.retire_areg[k*AREG_W +: AREG_W], q[k].areg);
      end
      for (int k = 0; k < mon_n; k++) void'(q.pop_front());
    end
  end

  task automatic do_op(input bit dv, input int t, input bit cv, input int cidx);
    bit accept;
    accept = dv && (q.size() < DEPTH);
    rif.dispatch_valid = dv;
    rif.dispatch_T     = TAG_W'(t);
    rif.dispatch_Told  = TAG_W'(t + 7);
    rif.dispatch_areg  = AREG_W'(t);
    rif.cdb_valid      = cv;
    rif.cdb_idx        = IDX_W'(cidx);
    if (accept) check_eq("dispatch_idx", rif.dispatch_idx, exp_tail);
    cyc();
    rif.dispatch_valid = 1'b0;
    rif.cdb_valid      = 1'b0;
    if (cv) begin
      foreach (q[i]) if (q[i].idx == IDX_W'(cidx)) q[i].done = 1'b1;
    end
    if (accept) begin
      q.push_back('{idx: exp_tail, t: TAG_W'(t), told: TAG_W'(t + 7), areg: AREG_W'(t), done: 1'b0});
      exp_tail = exp_tail + 1'b1;
    end
  endtask

  task automatic do_squash(input int sidx, input bit dv);
    bit hit = 1'b0;
    foreach (q[i]) if (q[i].idx == IDX_W'(sidx)) hit = 1'b1;
    rif.squash_valid   = 1'b1;
    rif.squash_idx     = IDX_W'(sidx);
    rif.dispatch_valid = dv;
    rif.dispatch_T     = TAG_W'(50);
    rif.dispatch_Told  = TAG_W'(51);
    rif.dispatch_areg  = AREG_W'(3);
    cyc();
    rif.squash_valid   = 1'b0;
    rif.dispatch_valid = 1'b0;
    if (hit) begin
      exp_tail = IDX_W'(sidx + 1);
      while ((q.size() > 0) && (q[$].idx != IDX_W'(sidx))) void'(q.pop_back());
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    q.delete();
    exp_tail = '0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (!rif.empty && (n < budget)) begin
      cyc();
      n++;
    end
    check_eq("drain_empty", rif.empty, 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [TAG_W-1:0] t31;
    rif.dispatch_valid = 1'b0;
    rif.dispatch_T     = '0;
    rif.dispatch_Told  = '0;
    rif.dispatch_areg  = '0;
    rif.cdb_valid      = 1'b0;
    rif.cdb_idx        = '0;
    rif.squash_valid   = 1'b0;
    rif.squash_idx     = '0;
    cyc();
    do_reset();
    check_eq("rst_count", rif.count, 64'd0);
    check_eq("rst_empty", rif.empty, 64'd1);
    check_eq("rst_full", rif.full, 64'd0);
    check_eq("rst_ready", rif.dispatch_ready, 64'd1);
    check_eq("rst_retire", rif.retire_valid, 64'd0);
    check_eq("rst_tail", rif.dispatch_idx, 64'd0);

    // Three dispatches, then out-of-order completion retiring two together.
    for (int i = 0; i < 3; i++) do_op(1'b1, 10 + i, 1'b0, 0);
    check_eq("t1_count", rif.count, 64'd3);
    check_eq("t1_noretire", rif.retire_valid, 64'd0);
    do_op(1'b0, 0, 1'b1, 1);
    check_eq("t2_hold", rif.retire_valid, 64'd0);
    do_op(1'b0, 0, 1'b1, 0);
    check_eq("t2_pair", rif.retire_valid, 64'b11);
    check_eq("t2_lane0_T", rif.retire_T[TAG_W-1:0], 64'd10);
    check_eq("t2_lane1_T", rif.retire_T[2*TAG_W-1:TAG_W], 64'd11);
    cyc();
    check_eq("t2_count", rif.count, 64'd1);

    // Fill to full, drop the extra dispatch, then drain RET_W per cycle.
    do_reset();
    for (int i = 0; i < DEPTH; i++) do_op(1'b1, 20 + i, 1'b0, 0);
    check_eq("t3_full", rif.full, 64'd1);
    check_eq("t3_ready", rif.dispatch_ready, 64'd0);
    do_op(1'b1, 7, 1'b0, 0);
    check_eq("t3_dropped", rif.count, 64'd32);
    for (int i = DEPTH - 1; i >= 0; i--) do_op(1'b0, 0, 1'b1, i);
    n = 0;
    while (!rif.empty && (n < 40)) begin
      cyc();
      n++;
    end
    check_eq("t3_drain_cycles", n, 64'd16);
    check_eq("t3_tail_wrap", rif.dispatch_idx, 64'd0);

    // Squash with a competing dispatch; CDB to a killed slot must not stick.
    for (int i = 0; i < 6; i++) do_op(1'b1, 30 + i, 1'b0, 0);
    do_squash(2, 1'b1);
    check_eq("t4_count", rif.count, 64'd3);
    check_eq("t4_tail", rif.dispatch_idx, 64'd3);
    do_squash(10, 1'b0);
    check_eq("t4_bad_squash", rif.count, 64'd3);
    do_op(1'b0, 0, 1'b1, 4);
    do_op(1'b1, 40, 1'b0, 0);
    do_op(1'b1, 41, 1'b0, 0);
    for (int i = 0; i < 4; i++) do_op(1'b0, 0, 1'b1, i);
    cyc();
    cyc();
    check_eq("t4_killed_cdb", rif.count, 64'd1);
    do_op(1'b0, 0, 1'b1, 4);
    drain(8);

    // Overlapped dispatch/complete/retire up to head 31, then a wrapping pair.
    for (int i = 0; i < 26; i++) do_op(1'b1, i, (i > 0), 5 + i - 1);
    do_op(1'b0, 0, 1'b1, 30);
    drain(40);
    check_eq("t5_tail31", rif.dispatch_idx, 64'd31);
    do_op(1'b1, 45, 1'b0, 0);
    t31 = TAG_W'(45);
    do_op(1'b1, 46, 1'b0, 0);
    do_op(1'b0, 0, 1'b1, 0);
    do_op(1'b0, 0, 1'b1, 31);
    check_eq("t5_pair", rif.retire_valid, 64'b11);
    check_eq("t5_lane0_T", rif.retire_T[TAG_W-1:0], t31);
    cyc();
    check_eq("t5_empty", rif.empty, 64'd1);
    check_eq("t5_head1", rif.dispatch_idx, 64'd1);

    // Reset with eight entries in flight.
    for (int i = 0; i < 8; i++) do_op(1'b1, 60 + i, 1'b0, 0);
    check_eq("t6_pre_count", rif.count, 64'd8);
    do_reset();
    check_eq("t6_count", rif.count, 64'd0);
    check_eq("t6_empty", rif.empty, 64'd1);
    check_eq("t6_retire", rif.retire_valid, 64'd0);
    cyc();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
